// File: rtl/gpi_ctrl_pkg.sv
// gpi_ctrl_pkg
// Shared definitions for the general-purpose input conditioner:
//   - gpi_offset_t : decoded register offset (device_addr_i[9:0])
//   - GPI_*_OFFSET : word-aligned register offsets
//   - be_to_mask   : expands 4 byte enables into a 32-bit bit mask
package gpi_ctrl_pkg;

   typedef logic [9:0] gpi_offset_t;

   localparam gpi_offset_t GPI_VALUE_OFFSET      = 10'h000;
   localparam gpi_offset_t GPI_RISE_EN_OFFSET    = 10'h004;
   localparam gpi_offset_t GPI_FALL_EN_OFFSET    = 10'h008;
   localparam gpi_offset_t GPI_INTR_STATE_OFFSET = 10'h00C;
   localparam gpi_offset_t GPI_DEBOUNCE_OFFSET   = 10'h010;
   localparam gpi_offset_t GPI_RAW_OFFSET        = 10'h014;

   // Each byte enable covers eight data bits.
   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int b = 0; b < 4; b++) begin
         mask[8*b +: 8] = {8{be[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce
// One input channel: 2-flop synchroniser, debounce counter, debounced level
// and single-cycle edge pulses.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   gpi_i         : raw asynchronous pad input
//   limit_i       : debounce limit; input must differ for limit_i+1 cycles
//   sync_o        : synchronised (not debounced) input
//   stable_o      : debounced level
//   rise_o/fall_o : high for the one cycle after stable_o changed 0->1 / 1->0
module gpi_debounce
   import gpi_ctrl_pkg::*;
#(
   parameter int unsigned CntWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                gpi_i,
   input  logic [CntWidth-1:0] limit_i,
   output logic                sync_o,
   output logic                stable_o,
   output logic                rise_o,
   output logic                fall_o
);

   logic                meta_q;
   logic                sync_q;
   logic                stable_q;
   logic                stable_prev_q;
   logic [CntWidth-1:0] cnt_q;

   // Two-stage synchroniser for the asynchronous pad.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= gpi_i;
         sync_q <= meta_q;
      end
   end

   // The counter measures how long sync has disagreed with stable. Any
   // agreement restarts it, so short glitches never commit. The compare uses
   // the live limit, so lowering the limit below a running count commits on
   // the next evaluation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         stable_prev_q <= stable_q;
         if (sync_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q >= limit_i) begin
            stable_q <= sync_q;
            cnt_q    <= '0;
         end else if (cnt_q != {CntWidth{1'b1}}) begin
            cnt_q <= cnt_q + CntWidth'(1);
         end
      end
   end

   assign sync_o   = sync_q;
   assign stable_o = stable_q;
   assign rise_o   = stable_q & ~stable_prev_q;
   assign fall_o   = ~stable_q & stable_prev_q;

endmodule

// File: rtl/gpi_ctrl.sv
// gpi_ctrl
// General-purpose input conditioner with a device-bus register interface.
// Each pin is synchronised and debounced; debounced edges set sticky
// pending bits, and irq_o is the registered OR of the pending bits.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   device_req_i    : single-cycle bus request
//   device_addr_i   : byte address, only [9:2] decoded
//   device_we_i     : write enable
//   device_be_i     : byte enables
//   device_wdata_i  : write data
//   device_rvalid_o : response valid, one cycle after each request
//   device_rdata_o  : read data (pre-write value; 0 for writes/unmapped)
//   gpi_i           : raw asynchronous pad inputs
//   irq_o           : level interrupt
module gpi_ctrl
   import gpi_ctrl_pkg::*;
#(
   parameter int unsigned GpiWidth = 8,
   parameter int unsigned CntWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                device_req_i,
   input  logic [31:0]         device_addr_i,
   input  logic                device_we_i,
   input  logic [3:0]          device_be_i,
   input  logic [31:0]         device_wdata_i,
   output logic                device_rvalid_o,
   output logic [31:0]         device_rdata_o,
   input  logic [GpiWidth-1:0] gpi_i,
   output logic                irq_o
);

   logic [GpiWidth-1:0] sync;
   logic [GpiWidth-1:0] stable;
   logic [GpiWidth-1:0] rise;
   logic [GpiWidth-1:0] fall;

   logic [GpiWidth-1:0] rise_en_q;
   logic [GpiWidth-1:0] fall_en_q;
   logic [GpiWidth-1:0] intr_state_q;
   logic [CntWidth-1:0] debounce_q;

   logic                rvalid_q;
   logic [31:0]         rdata_q;
   logic                irq_q;

   gpi_offset_t         offset;
   logic [31:0]         wmask;
   logic [31:0]         wbits;
   logic                wr_en;
   logic [GpiWidth-1:0] intr_set;
   logic [GpiWidth-1:0] intr_clr;
   logic [31:0]         rdata_d;
   logic                unused_bits;

   for (genvar i = 0; i < GpiWidth; i++) begin : g_chan
      gpi_debounce #(
         .CntWidth (CntWidth)
      ) u_debounce (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .gpi_i    (gpi_i[i]),
         .limit_i  (debounce_q),
         .sync_o   (sync[i]),
         .stable_o (stable[i]),
         .rise_o   (rise[i]),
         .fall_o   (fall[i])
      );
   end

   // addr[1:0] is ignored, so every access is treated as word aligned.
   assign offset = {device_addr_i[9:2], 2'b00};
   assign wmask  = be_to_mask(device_be_i);
   assign wbits  = device_wdata_i & wmask;
   assign wr_en  = device_req_i & device_we_i;

   assign intr_set = (rise & rise_en_q) | (fall & fall_en_q);
   assign intr_clr = (wr_en && offset == GPI_INTR_STATE_OFFSET) ?
                     wbits[GpiWidth-1:0] : '0;

   // Address bits outside the decode and mask bits above the field widths
   // are intentionally dropped.
   assign unused_bits = ^{device_addr_i[31:10], device_addr_i[1:0], wmask, wbits};

   // Register file. Writes merge only the enabled bytes. The pending bits
   // apply the clear first and the set second so a new event survives a
   // simultaneous write-one-to-clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rise_en_q    <= '0;
         fall_en_q    <= '0;
         intr_state_q <= '0;
         debounce_q   <= '0;
      end else begin
         if (wr_en && offset == GPI_RISE_EN_OFFSET) begin
            rise_en_q <= (rise_en_q & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
         end
         if (wr_en && offset == GPI_FALL_EN_OFFSET) begin
            fall_en_q <= (fall_en_q & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
         end
         if (wr_en && offset == GPI_DEBOUNCE_OFFSET) begin
            debounce_q <= (debounce_q & ~wmask[CntWidth-1:0]) | wbits[CntWidth-1:0];
         end
         intr_state_q <= (intr_state_q & ~intr_clr) | intr_set;
      end
   end

   // Read mux; fields are zero-extended and unmapped offsets read 0.
   always_comb begin
      rdata_d = '0;
      case (offset)
         GPI_VALUE_OFFSET:      rdata_d[GpiWidth-1:0] = stable;
         GPI_RISE_EN_OFFSET:    rdata_d[GpiWidth-1:0] = rise_en_q;
         GPI_FALL_EN_OFFSET:    rdata_d[GpiWidth-1:0] = fall_en_q;
         GPI_INTR_STATE_OFFSET: rdata_d[GpiWidth-1:0] = intr_state_q;
         GPI_DEBOUNCE_OFFSET:   rdata_d[CntWidth-1:0] = debounce_q;
         GPI_RAW_OFFSET:        rdata_d[GpiWidth-1:0] = sync;
         default:               rdata_d = '0;
      endcase
   end

   // Every request gets exactly one response the following cycle. Reads
   // capture the register value before any same-cycle update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= device_req_i;
         if (device_req_i) begin
            rdata_q <= device_we_i ? '0 : rdata_d;
         end
      end
   end

   // Interrupt is registered so it lags the pending bits by one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |intr_state_q;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;
   assign irq_o           = irq_q;

endmodule

// File: tb/tb_gpi_ctrl.sv
// tb_gpi_ctrl
// Scoreboard bench for gpi_ctrl: bus accesses push their expected read data,
// a monitor pops and compares whenever rvalid is seen.
module tb_gpi_ctrl;

   localparam int GpiWidth = 8;
   localparam int CntWidth = 16;

   localparam logic [31:0] VALUE   = 32'h00;
   localparam logic [31:0] RISE_EN = 32'h04;
   localparam logic [31:0] FALL_EN = 32'h08;
   localparam logic [31:0] INTR    = 32'h0C;
   localparam logic [31:0] DEBOUNC = 32'h10;
   localparam logic [31:0] RAW     = 32'h14;

   logic                clk_i = 1'b0;
   logic                rst_ni = 1'b0;
   logic                device_req_i = 1'b0;
   logic [31:0]         device_addr_i = '0;
   logic                device_we_i = 1'b0;
   logic [3:0]          device_be_i = '0;
   logic [31:0]         device_wdata_i = '0;
   logic                device_rvalid_o;
   logic [31:0]         device_rdata_o;
   logic [GpiWidth-1:0] gpi_i = '0;
   logic                irq_o;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp_q[$];
   string       lbl_q[$];
   logic        req_d;

   gpi_ctrl #(
      .GpiWidth (GpiWidth),
      .CntWidth (CntWidth)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .device_req_i    (device_req_i),
      .device_addr_i   (device_addr_i),
      .device_we_i     (device_we_i),
      .device_be_i     (device_be_i),
      .device_wdata_i  (device_wdata_i),
      .device_rvalid_o (device_rvalid_o),
      .device_rdata_o  (device_rdata_o),
      .gpi_i           (gpi_i),
      .irq_o           (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Issues one bus request (sampled at the next rising edge) and records the
   // expected response; returns 1ns after that edge.
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input string name);
      device_req_i   = 1'b1;
      device_we_i    = we;
      device_addr_i  = addr;
      device_wdata_i = wdata;
      device_be_i    = be;
      exp_q.push_back(we ? 32'h0 : exp_rdata);
      lbl_q.push_back(name);
      @(posedge clk_i);
      #1;
      device_req_i = 1'b0;
      device_we_i  = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input string name);
      applyStimulus(1'b0, addr, 32'h0, 4'h0, exp_rdata, name);
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
      applyStimulus(1'b1, addr, wdata, be, 32'h0, "wr_rdata");
   endtask

   // Reference for rvalid: the request as seen at the previous edge.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) req_d <= 1'b0;
      else         req_d <= device_req_i;
   end

   // Monitor: compares every response against the head of the scoreboard.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (req_d || device_rvalid_o) begin
            checkOutput("rvalid_latency", 32'(device_rvalid_o), 32'(req_d));
         end
         if (device_rvalid_o) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_rvalid: rdata 0x%08h with no request pending",
                        device_rdata_o);
            end else begin
               checkOutput(lbl_q.pop_front(), device_rdata_o, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset and read-back of every register.
      waitCycles(3);
      checkOutput("reset_irq", 32'(irq_o), 32'h0);
      checkOutput("reset_rvalid", 32'(device_rvalid_o), 32'h0);
      rst_ni = 1'b1;
      waitCycles(1);
      busRead(VALUE,   32'h0, "rst_value");
      busRead(RISE_EN, 32'h0, "rst_rise_en");
      busRead(FALL_EN, 32'h0, "rst_fall_en");
      busRead(INTR,    32'h0, "rst_intr");
      busRead(DEBOUNC, 32'h0, "rst_debounce");
      busRead(RAW,     32'h0, "rst_raw");

      // limit 0: stable after 3 edges, pending one later, irq one after that.
      busWrite(RISE_EN, 32'h01, 4'hF);
      gpi_i[0] = 1'b1;
      busRead(VALUE, 32'h0, "t2_value_e1");
      busRead(VALUE, 32'h0, "t2_value_e2");
      busRead(VALUE, 32'h0, "t2_value_e3");
      busRead(VALUE, 32'h1, "t2_value_e4");
      checkOutput("t2_irq_e4", 32'(irq_o), 32'h0);
      busRead(INTR, 32'h1, "t2_intr_e5");
      checkOutput("t2_irq_e5", 32'(irq_o), 32'h1);

      // limit 10: a 5-cycle glitch is filtered, a held step lands at edge 13.
      busWrite(INTR, 32'h01, 4'hF);
      busWrite(RISE_EN, 32'h02, 4'hF);
      busWrite(DEBOUNC, 32'd10, 4'hF);
      waitCycles(2);
      checkOutput("t3_irq_cleared", 32'(irq_o), 32'h0);
      gpi_i[1] = 1'b1;
      waitCycles(5);
      gpi_i[1] = 1'b0;
      waitCycles(20);
      busRead(VALUE, 32'h1, "t3_glitch_value");
      busRead(INTR,  32'h0, "t3_glitch_intr");
      checkOutput("t3_glitch_irq", 32'(irq_o), 32'h0);
      gpi_i[1] = 1'b1;
      waitCycles(12);
      busRead(VALUE, 32'h1, "t3_value_e13");
      busRead(VALUE, 32'h3, "t3_value_e14");
      waitCycles(6);
      busRead(INTR, 32'h2, "t3_intr");
      checkOutput("t3_irq", 32'(irq_o), 32'h1);
      busWrite(INTR, 32'h02, 4'hF);
      waitCycles(2);

      // Set wins over a simultaneous W1C; a later W1C clears it.
      busWrite(DEBOUNC, 32'h0, 4'hF);
      busWrite(FALL_EN, 32'h04, 4'hF);
      gpi_i[2] = 1'b1;
      waitCycles(5);
      gpi_i[2] = 1'b0;
      waitCycles(6);
      busRead(INTR, 32'h4, "t4_first_fall");
      gpi_i[2] = 1'b1;
      waitCycles(5);
      gpi_i[2] = 1'b0;
      waitCycles(3);
      busWrite(INTR, 32'h04, 4'hF);
      busRead(INTR, 32'h4, "t4_set_wins");
      checkOutput("t4_irq_set", 32'(irq_o), 32'h1);
      waitCycles(2);
      busWrite(INTR, 32'h04, 4'hF);
      checkOutput("t4_irq_hold", 32'(irq_o), 32'h1);
      waitCycles(1);
      checkOutput("t4_irq_drop", 32'(irq_o), 32'h0);
      busRead(INTR, 32'h0, "t4_intr_cleared");

      // Byte enables, field width, address decode, unmapped offsets.
      busWrite(DEBOUNC, 32'h0000ABCD, 4'b0001);
      busRead(DEBOUNC, 32'h000000CD, "t5_be_byte0");
      busWrite(DEBOUNC, 32'hFFFF1234, 4'b1110);
      busRead(DEBOUNC, 32'h000012CD, "t5_be_upper");
      busWrite(32'h20, 32'hFFFFFFFF, 4'hF);
      busRead(32'h20, 32'h0, "t5_unmapped_20");
      busRead(32'h18, 32'h0, "t5_unmapped_18");
      busRead(RISE_EN, 32'h2, "t5_rise_en_kept");
      busRead(FALL_EN, 32'h4, "t5_fall_en_kept");
      busWrite(RISE_EN, 32'hFFFFFF02, 4'hF);
      busRead(RISE_EN, 32'h2, "t5_width_mask");
      busRead(32'hFFFFF406, 32'h2, "t5_addr_decode");
      busRead(RAW,   32'h3, "t5_raw");
      busRead(VALUE, 32'h3, "t5_value");

      // Reset mid-debounce and mid-request with all pending bits set.
      busWrite(DEBOUNC, 32'h0, 4'hF);
      busWrite(RISE_EN, 32'hFF, 4'hF);
      busWrite(FALL_EN, 32'hFF, 4'hF);
      gpi_i = 8'h00;
      waitCycles(6);
      gpi_i = 8'hFF;
      waitCycles(6);
      busRead(INTR, 32'hFF, "t6_intr_all");
      busWrite(DEBOUNC, 32'd10, 4'hF);
      checkOutput("t6_irq_before", 32'(irq_o), 32'h1);
      gpi_i = 8'h00;
      waitCycles(6);
      device_req_i  = 1'b1;
      device_addr_i = VALUE;
      #2;
      rst_ni       = 1'b0;
      device_req_i = 1'b0;
      #1;
      checkOutput("t6_irq_in_reset", 32'(irq_o), 32'h0);
      checkOutput("t6_rvalid_in_reset", 32'(device_rvalid_o), 32'h0);
      waitCycles(2);
      rst_ni = 1'b1;
      waitCycles(2);
      checkOutput("t6_irq_after", 32'(irq_o), 32'h0);
      busRead(VALUE,   32'h0, "t6_value");
      busRead(INTR,    32'h0, "t6_intr");
      busRead(DEBOUNC, 32'h0, "t6_debounce");
      busWrite(DEBOUNC, 32'd10, 4'hF);
      gpi_i[3] = 1'b1;
      waitCycles(12);
      busRead(VALUE, 32'h0, "t6_restart_e13");
      busRead(VALUE, 32'h8, "t6_restart_e14");

      waitCycles(3);
      checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
